// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace monitor.
// Record fields are sized for the widest build (XLEN <= 64, NR_GPR <= 32).
package commit_trace_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_e;

   localparam int TRACE_XLEN  = 64;
   localparam int TRACE_IDX_W = 5;
   localparam int A0_IDX      = 10;

   localparam logic [TRACE_XLEN-1:0] TIMEOUT_CODE = '1;

   typedef struct packed {
      logic [TRACE_XLEN-1:0]  pc;
      logic [31:0]            inst;
      logic                   rd_wen;
      logic [TRACE_IDX_W-1:0] rd_idx;
      logic [TRACE_XLEN-1:0]  rd_data;
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; the head is read straight from storage.
// A pop frees its slot for a push on the same edge, even when full.
module trace_fifo #(
   parameter type rec_t = logic [7:0],
   parameter int  DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  rec_t push_data,
   input  logic pop,
   output rec_t head,
   output logic full,
   output logic empty
);
   localparam int PW = $clog2(DEPTH);

   rec_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit-stage monitor: trace FIFO, shadow GPR file, counters, watchdog
// and the RUN/DRAIN/HALTED sequencer that produces halt and its exit code.
module commit_trace_monitor
   import commit_trace_pkg::*;
#(
   parameter  int XLEN       = 64,
   parameter  int NR_GPR     = 32,
   parameter  int FIFO_DEPTH = 8,
   parameter  int TIMEOUT    = 65535,
   localparam int IDX_W      = $clog2(NR_GPR)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             commit_valid,
   output logic             commit_ready,
   input  logic [XLEN-1:0]  commit_pc,
   input  logic [31:0]      commit_inst,
   input  logic             commit_rd_wen,
   input  logic [IDX_W-1:0] commit_rd_idx,
   input  logic [XLEN-1:0]  commit_rd_data,
   input  logic             commit_is_break,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [XLEN-1:0]  trace_pc,
   output logic [31:0]      trace_inst,
   output logic             trace_rd_wen,
   output logic [IDX_W-1:0] trace_rd_idx,
   output logic [XLEN-1:0]  trace_rd_data,
   input  logic [IDX_W-1:0] gpr_rd_idx,
   output logic [XLEN-1:0]  gpr_rd_data,
   output logic [63:0]      cycle_cnt,
   output logic [63:0]      instret_cnt,
   output logic             halt,
   output logic             halt_timeout,
   output logic [XLEN-1:0]  halt_code
);
   localparam int WD_W = 32;

   state_e          state_q, state_d;
   logic            timeout_q, timeout_d;
   logic [XLEN-1:0] halt_code_q, halt_code_d;
   logic [XLEN-1:0] gpr_q [NR_GPR];
   logic [63:0]     cycle_q;
   logic [63:0]     instret_q;
   logic [WD_W-1:0] wdog_q;
   logic            fifo_full;
   logic            fifo_empty;
   logic            accept;
   logic            wd_expire;
   trace_rec_t      push_rec;
   trace_rec_t      head_rec;

   assign commit_ready = (state_q == RUN) && !fifo_full;
   assign accept       = commit_valid && commit_ready;

   always_comb begin
      push_rec         = '0;
      push_rec.pc      = TRACE_XLEN'(commit_pc);
      push_rec.inst    = commit_inst;
      push_rec.rd_wen  = commit_rd_wen;
      push_rec.rd_idx  = TRACE_IDX_W'(commit_rd_idx);
      push_rec.rd_data = TRACE_XLEN'(commit_rd_data);
   end

   trace_fifo #(
      .rec_t (trace_rec_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (push_rec),
      .pop       (trace_ready),
      .head      (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign trace_valid   = !fifo_empty;
   assign trace_pc      = head_rec.pc[XLEN-1:0];
   assign trace_inst    = head_rec.inst;
   assign trace_rd_wen  = head_rec.rd_wen;
   assign trace_rd_idx  = head_rec.rd_idx[IDX_W-1:0];
   assign trace_rd_data = head_rec.rd_data[XLEN-1:0];

   // x0 is never written, so it keeps its reset value of zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NR_GPR; i++) gpr_q[i] <= '0;
      end else if (accept && commit_rd_wen && commit_rd_idx != '0) begin
         gpr_q[commit_rd_idx] <= commit_rd_data;
      end
   end

   assign gpr_rd_data = gpr_q[gpr_rd_idx];

   always_ff @(posedge clk) begin
      if (!rst_n || accept || state_q != RUN) wdog_q <= '0;
      else                                    wdog_q <= wdog_q + 1'b1;
   end

   // Fires on the edge where the idle count reaches TIMEOUT.
   assign wd_expire = (TIMEOUT != 0) && (state_q == RUN) && !accept &&
                      (wdog_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      timeout_d   = timeout_q;
      halt_code_d = halt_code_q;
      case (state_q)
         RUN: begin
            if (accept && commit_is_break) begin
               state_d     = DRAIN;
               timeout_d   = 1'b0;
               halt_code_d = gpr_q[IDX_W'(A0_IDX)];
            end else if (wd_expire) begin
               state_d     = DRAIN;
               timeout_d   = 1'b1;
               halt_code_d = TIMEOUT_CODE[XLEN-1:0];
            end
         end
         DRAIN:   if (fifo_empty) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         timeout_q   <= 1'b0;
         halt_code_q <= '0;
         cycle_q     <= '0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         timeout_q   <= timeout_d;
         halt_code_q <= halt_code_d;
         cycle_q     <= cycle_q + 64'd1;
         instret_q   <= instret_q + 64'(accept);
      end
   end

   assign cycle_cnt    = cycle_q;
   assign instret_cnt  = instret_q;
   assign halt         = (state_q == HALTED);
   assign halt_timeout = halt && timeout_q;
   assign halt_code    = halt_code_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench: the driver queues expected trace records on each accept,
// an independent monitor pops and compares them as the DUT presents them.
module tb_commit_trace_monitor;
   localparam int XLEN       = 64;
   localparam int NR_GPR     = 32;
   localparam int FIFO_DEPTH = 8;
   localparam int TIMEOUT    = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        commit_valid = 1'b0;
   logic        commit_ready;
   logic [63:0] commit_pc = '0;
   logic [31:0] commit_inst = '0;
   logic        commit_rd_wen = 1'b0;
   logic [4:0]  commit_rd_idx = '0;
   logic [63:0] commit_rd_data = '0;
   logic        commit_is_break = 1'b0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [63:0] trace_pc;
   logic [31:0] trace_inst;
   logic        trace_rd_wen;
   logic [4:0]  trace_rd_idx;
   logic [63:0] trace_rd_data;
   logic [4:0]  gpr_rd_idx = '0;
   logic [63:0] gpr_rd_data;
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;
   logic        halt;
   logic        halt_timeout;
   logic [63:0] halt_code;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  idx;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;
   int   pop_cnt = 0;

   always #5 clk = ~clk;

   commit_trace_monitor #(
      .XLEN(XLEN), .NR_GPR(NR_GPR), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_inst(commit_inst),
      .commit_rd_wen(commit_rd_wen), .commit_rd_idx(commit_rd_idx),
      .commit_rd_data(commit_rd_data), .commit_is_break(commit_is_break),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_inst(trace_inst),
      .trace_rd_wen(trace_rd_wen), .trace_rd_idx(trace_rd_idx),
      .trace_rd_data(trace_rd_data),
      .gpr_rd_idx(gpr_rd_idx), .gpr_rd_data(gpr_rd_data),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
      .halt(halt), .halt_timeout(halt_timeout), .halt_code(halt_code)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            check("trace_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("trace_pc", trace_pc, mon_e.pc);
            check("trace_fields", 64'({trace_inst, trace_rd_wen, trace_rd_idx}),
                  64'({mon_e.inst, mon_e.wen, mon_e.idx}));
            check("trace_data", trace_rd_data, mon_e.data);
            $display("trace pop pc=0x%0h inst=0x%08h wen=%0b rd=%0d data=0x%0h",
                     trace_pc, trace_inst, trace_rd_wen, trace_rd_idx, trace_rd_data);
         end
         pop_cnt++;
      end
   end

   task automatic do_reset();
      rst_n        = 1'b0;
      commit_valid = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic set_commit(input logic [63:0] pc, input logic [4:0] idx,
                             input logic [63:0] data, input logic wen, input logic brk);
      commit_valid    = 1'b1;
      commit_pc       = pc;
      commit_inst     = brk ? 32'h0010_0073 : {12'h0, 5'd0, 3'b000, idx, 7'h13} ^ pc[31:0];
      commit_rd_wen   = wen;
      commit_rd_idx   = idx;
      commit_rd_data  = data;
      commit_is_break = brk;
   endtask

   task automatic commit(input logic [63:0] pc, input logic [4:0] idx,
                         input logic [63:0] data, input logic wen, input logic brk);
      exp_t e;
      bit   done = 0;
      set_commit(pc, idx, data, wen, brk);
      e.pc = pc; e.inst = commit_inst; e.wen = wen; e.idx = idx; e.data = data;
      for (int w = 0; w < 50 && !done; w++) begin
         @(negedge clk);
         if (commit_ready) begin
            exp_q.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("commit_accept_timeout", 64'd0, 64'd1);
      $display("commit pc=0x%0h rd=%0d data=0x%0h brk=%0b accepted=%0b", pc, idx, data, brk, done);
   endtask

   task automatic idle(input int n);
      commit_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  base;
      bit  early;
      do_reset();
      check("rst_halt", 64'(halt), 64'd0);
      check("rst_halt_timeout", 64'(halt_timeout), 64'd0);
      check("rst_trace_valid", 64'(trace_valid), 64'd0);
      check("rst_commit_ready", 64'(commit_ready), 64'd1);
      check("rst_cycle_cnt", cycle_cnt, 64'd0);
      check("rst_instret", instret_cnt, 64'd0);

      // three commits, harness always ready
      trace_ready = 1'b1;
      commit(64'h1000, 5'd5, 64'h11, 1'b1, 1'b0);
      commit(64'h1004, 5'd10, 64'h2A, 1'b1, 1'b0);
      commit(64'h1008, 5'd0, 64'hFF, 1'b1, 1'b0);
      idle(4);
      check("t1_instret", instret_cnt, 64'd3);
      gpr_rd_idx = 5'd5;  #1; check("t1_gpr_x5", gpr_rd_data, 64'h11);
      gpr_rd_idx = 5'd10; #1; check("t1_gpr_x10", gpr_rd_data, 64'h2A);
      gpr_rd_idx = 5'd0;  #1; check("t1_gpr_x0", gpr_rd_data, 64'h0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // backpressure: 8 accepted, then ready drops
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 8; i++) commit(64'h2000 + 64'(i * 4), 5'd6, 64'(i), 1'b1, 1'b0);
      check("t2_ready_full", 64'(commit_ready), 64'd0);
      check("t2_instret8", instret_cnt, 64'd8);
      set_commit(64'h2020, 5'd7, 64'h8, 1'b1, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("t2_no_accept_full", instret_cnt, 64'd8);
      trace_ready = 1'b1;
      commit(64'h2020, 5'd7, 64'h8, 1'b1, 1'b0);
      commit(64'h2024, 5'd7, 64'h9, 1'b1, 1'b0);
      idle(12);
      check("t2_instret10", instret_cnt, 64'd10);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // full FIFO with simultaneous push and pop
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 8; i++) commit(64'h3000 + 64'(i * 4), 5'd8, 64'h100 + 64'(i), 1'b1, 1'b0);
      trace_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         commit(64'h3100 + 64'(i * 4), 5'd9, 64'h200 + 64'(i), 1'b1, 1'b0);
         check("t3_trace_valid", 64'(trace_valid), 64'd1);
      end
      idle(12);
      check("t3_instret13", instret_cnt, 64'd13);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // ebreak drain with toggling trace_ready
      do_reset();
      trace_ready = 1'b0;
      commit(64'h4000, 5'd10, 64'h55, 1'b1, 1'b0);
      commit(64'h4004, 5'd7, 64'h3, 1'b1, 1'b0);
      commit(64'h4008, 5'd10, 64'h0, 1'b1, 1'b0);
      commit(64'h400C, 5'd8, 64'h4, 1'b1, 1'b0);
      commit(64'h4010, 5'd10, 64'h99, 1'b1, 1'b1);
      commit_valid = 1'b0;
      check("t4_ready_after_break", 64'(commit_ready), 64'd0);
      base  = pop_cnt;
      early = 0;
      for (int c = 0; c < 40 && !halt; c++) begin
         trace_ready = ~trace_ready;
         @(posedge clk); #1;
         if (halt && (pop_cnt - base) < 5) early = 1;
      end
      check("t4_halt", 64'(halt), 64'd1);
      check("t4_halt_not_early", 64'(early), 64'd0);
      check("t4_pops", 64'(pop_cnt - base), 64'd5);
      check("t4_halt_code", halt_code, 64'h0);
      check("t4_halt_timeout", 64'(halt_timeout), 64'd0);
      gpr_rd_idx = 5'd10; #1; check("t4_gpr_x10", gpr_rd_data, 64'h99);
      idle(3);
      check("t4_halt_hold", 64'(halt), 64'd1);
      check("t4_ready_halted", 64'(commit_ready), 64'd0);

      // watchdog with no commits
      trace_ready = 1'b1;
      do_reset();
      check("t5_cycle0", cycle_cnt, 64'd0);
      for (int c = 0; c < 40 && !halt; c++) begin
         @(posedge clk); #1;
      end
      check("t5_halt", 64'(halt), 64'd1);
      check("t5_halt_cycle", cycle_cnt, 64'd21);
      check("t5_halt_timeout", 64'(halt_timeout), 64'd1);
      check("t5_halt_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFF);
      idle(5);
      check("t5_cycle_runs", cycle_cnt, 64'd26);

      // reset while draining
      do_reset();
      trace_ready = 1'b0;
      commit(64'h5000, 5'd3, 64'h1, 1'b1, 1'b0);
      commit(64'h5004, 5'd4, 64'h2, 1'b1, 1'b0);
      commit(64'h5008, 5'd0, 64'h0, 1'b0, 1'b1);
      commit_valid = 1'b0;
      check("t6_in_drain", 64'(commit_ready), 64'd0);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("t6_trace_valid", 64'(trace_valid), 64'd0);
      check("t6_cycle", cycle_cnt, 64'd0);
      check("t6_instret", instret_cnt, 64'd0);
      check("t6_halt", 64'(halt), 64'd0);
      check("t6_commit_ready", 64'(commit_ready), 64'd1);
      gpr_rd_idx = 5'd3; #1; check("t6_gpr_cleared", gpr_rd_data, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Parametrised successor to the simulation-side halt/register model.
- Sits between the core's commit stage and the C++ simulation harness.
- Captures each retired instruction into a trace FIFO and keeps a shadow GPR file updated from commits, so the harness reads one indexed port instead of NR_GPR wide buses.
- Detects ebreak and commit-watchdog timeout, drains the FIFO, then raises halt with an exit code.

Parameters:
- XLEN, 64: datapath width of pc, rd data, shadow GPRs.
- NR_GPR, 32: architectural register count (16 for RV32E/RV64E builds).
- FIFO_DEPTH, 8: trace FIFO entries. Must be a power of 2 and at least 2.
- TIMEOUT, 65535: cycles without a commit before a timeout halt. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- commit_valid  in  1  core presents a retired instruction
- commit_ready  out  1  monitor accepts it; the core stalls commit while this is low
- commit_pc  in  XLEN  pc of the retired instruction
- commit_inst  in  32  instruction word
- commit_rd_wen  in  1  instruction writes rd
- commit_rd_idx  in  $clog2(NR_GPR)  rd index
- commit_rd_data  in  XLEN  rd write data
- commit_is_break  in  1  retired instruction is ebreak
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  harness pops the head
- trace_pc, trace_inst, trace_rd_wen, trace_rd_idx, trace_rd_data  out  as commit_*  FIFO head record
- gpr_rd_idx  in  $clog2(NR_GPR)  shadow GPR read index
- gpr_rd_data  out  XLEN  shadow GPR value (combinational read)
- cycle_cnt  out  64  cycles since reset
- instret_cnt  out  64  accepted commits since reset
- halt  out  1  simulation finished
- halt_timeout  out  1  halt was caused by the watchdog
- halt_code  out  XLEN  exit code

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to RUN; FIFO is emptied; shadow GPRs, counters and halt_code are cleared.
  - halt=0, halt_timeout=0, trace_valid=0, commit_ready=1 from the first cycle after reset.
  - Reset mid-drain or while halted behaves the same way; pending trace records are discarded.
- Accept:
  - commit_ready = (state==RUN) && !fifo_full.
  - A commit is accepted when commit_valid && commit_ready at a clk edge.
- On accept:
  - Push one record into the FIFO.
  - instret_cnt += 1.
  - If commit_rd_wen and commit_rd_idx != 0, write the shadow GPR. Writes to x0 are dropped; x0 always reads 0.
- Shadow GPR read: gpr_rd_data reflects a write one cycle after its commit is accepted. There is no same-cycle bypass.
- FIFO:
  - Registered-head, first-word-fall-through style; trace_valid = !empty.
  - A push into an empty FIFO becomes visible on trace_valid the next cycle.
  - Push and pop in the same cycle are allowed at any occupancy, including full, where pop frees the slot that push uses that cycle. Occupancy is unchanged.
  - commit_ready uses registered fullness only; it is not combinationally raised by trace_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- cycle_cnt increments every cycle out of reset and keeps counting while halted. Both counters wrap at 2^64.
- Watchdog:
  - Counter clears on every accepted commit and while state != RUN; otherwise it increments.
  - Stalls caused by a full FIFO also count, so a harness that never pops will trip it.
  - When the counter reaches TIMEOUT (and TIMEOUT != 0), go to DRAIN with halt_timeout pending.
- FSM (2-bit state: RUN, DRAIN, HALTED):
  - RUN -> DRAIN when an accepted commit has commit_is_break=1. That ebreak record is still pushed.
  - RUN -> DRAIN on watchdog expiry.
  - If the ebreak is accepted on the same edge the watchdog expires, ebreak wins: halt_timeout=0.
  - DRAIN -> HALTED when the FIFO is empty, i.e. the last record has been popped.
  - HALTED is absorbing until reset.
- halt_code:
  - Latched on entry to DRAIN.
  - For ebreak: shadow x10 (a0) including any write from commits accepted before the ebreak. The ebreak's own rd write is not included.
  - For timeout: all-ones.
- halt and halt_timeout assert in the cycle the FSM is in HALTED and hold until reset.

Decomposition:
- Package commit_trace_pkg holds:
  - state enum (RUN, DRAIN, HALTED);
  - the packed trace_rec_t struct (pc, inst, rd_wen, rd_idx, rd_data);
  - the localparam A0_IDX = 10;
  - the TIMEOUT_CODE all-ones constant.
- One sub-module: trace_fifo, parametrised on record type/width and depth, with push/pop/full/empty.
- The shadow GPR file, counters, watchdog and FSM live in the top module.

Test Plan:
- Reset, then 3 commits (x5=0x11, x10=0x2A, x0=0xFF) with trace_ready=1 -> instret_cnt=3; gpr x5=0x11, x10=0x2A, x0=0; three trace records in order.
- Hold trace_ready=0, issue 10 commits with FIFO_DEPTH=8 -> commit_ready drops after 8 accepts; instret_cnt=8. Raise trace_ready -> the remaining 2 are accepted, with no loss or duplication.
- With the FIFO full, assert push and pop in the same cycle for 5 cycles -> occupancy stays 8; records emerge in order.
- Write x10=0x0, then ebreak with 4 records queued and trace_ready toggling -> commit_ready=0 after the ebreak; halt asserts only after the 5th pop; halt_code=0; halt_timeout=0.
- TIMEOUT=20, no commits after reset -> halt=1 and halt_timeout=1 at cycle 21; halt_code=all-ones; cycle_cnt keeps incrementing.
- Assert rst_n=0 while in DRAIN with 3 records queued -> the next cycle shows state RUN, trace_valid=0, counters=0, halt=0, commit_ready=1.
